mips_cpu_alu_regfile: RTL and testbench
=======================================

# mips_cpu_alu_regfile

Execution core of the multicycle MIPS CPU: a 32-entry × 32-bit general-purpose register file (two combinational read ports, one synchronous write port, `$zero` hardwired) plus a combinational 32-bit integer ALU with shift support and a zero flag. The bus-level CPU controller drives register addresses, ALU operands and control codes, and takes the ALU result for address generation and write-back. `register_v0` exposes `$2` for test observation.

## Interface
- No parameters.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on rising `clk`; `reset==0` resets).
- `writeEnable`  in  1  register write strobe.
- `writeAddress`  in  5  destination register index.
- `dataIn`  in  32  write data.
- `readAddressA`  in  5  read port A index.
- `readDataA`  out  32  contents of register `readAddressA`.
- `readAddressB`  in  5  read port B index.
- `readDataB`  out  32  contents of register `readAddressB`.
- `register_v0`  out  32  contents of register 2, always.
- `control`  in  4  ALU operation code.
- `a`  in  32  ALU operand A (rs / variable shift amount source).
- `b`  in  32  ALU operand B (rt or sign-extended immediate).
- `sa`  in  5  constant shift amount.
- `r`  out  32  ALU result.
- `zero`  out  1  high when `r == 0`.

## Operation
Register file:
- 32 × 32-bit storage; register 0 always reads 0 and ignores writes.
- Write: on rising `clk`, if `reset==1`, `writeEnable==1` and `writeAddress!=0`, the register is loaded with `dataIn`.
- Reads are combinational from `readAddressA` and `readAddressB`, with no write-to-read bypass. A read of the register being written returns the old value until the edge, then the new value.
- Both ports may address the same register simultaneously, and both return the same value.
- Reset: on rising `clk` with `reset==0`, all 32 registers are cleared to 0. Reset overrides any write in the same cycle.

ALU (purely combinational; `clk`/`reset` do not affect it). Codes for `control`:
- 0000 AND: `a & b`.
- 0001 OR: `a | b`.
- 0010 XOR: `a ^ b`.
- 0011 LUI: `{b[15:0], 16'h0}`.
- 0100 ADD: `a + b`, modulo 2^32, no overflow detection (serves ADDU, ADDIU, load/store address).
- 0101 SUB: `a - b`, modulo 2^32.
- 0110 SLT: 1 if signed `a` < signed `b`, else 0.
- 0111 SLTU: 1 if unsigned `a` < unsigned `b`, else 0.
- 1000 SLL: `b << sa`.
- 1001 SRL: `b >> sa`, logical.
- 1010 SRA: `b >>> sa`, arithmetic.
- 1011 SLLV: `b << a[4:0]`.
- 1100 SRLV: `b >> a[4:0]`, logical.
- 1101 SRAV: `b >>> a[4:0]`, arithmetic.
- 1110 PASS: `r = a`.
- 1111 DEFAULT/unused: `r = 0`.
- `zero = (r == 32'h0)` for every code; e.g. DEFAULT gives `zero = 1`.
- Variable shifts use only the low 5 bits of `a`; upper bits of `a` are ignored.

## Timing
- Register write latency is one edge: data written at edge N is visible on the read ports and `register_v0` combinationally after edge N.
- Read and ALU paths have zero-cycle latency; outputs follow inputs within the same cycle.
- After a reset edge: every register is 0, so `readDataA`, `readDataB` and `register_v0` read 0. ALU outputs depend only on their inputs.
- Reset asserted mid-operation discards all register contents at that edge. Writes attempted while `reset==0` are lost.
- There are no handshakes, stalls or internal FSM; the controller sequences everything.

## Test plan
- Reset then read: `reset=0` for one edge → `readDataA`, `readDataB` and `register_v0` all read 0 for every index 0–31.
- Write/read and `$zero`:
  - Write 0xDEADBEEF to r2 → `register_v0 = 0xDEADBEEF` after the edge, and the value is readable on both ports.
  - Write 0x12345678 to r0 → r0 still reads 0.
  - With `writeEnable=0`, a write to r5 leaves r5 unchanged.
- Reset priority: `reset=0` and `writeEnable=1`, writing 0x55 to r7 on the same edge → r7 reads 0.
- Arithmetic:
  - ADD 0xFFFFFFFF + 1 → `r = 0`, `zero = 1`.
  - ADD 0x7FFFFFFF + 1 → 0x80000000, `zero = 0`.
  - SUB 5 − 7 → 0xFFFFFFFE.
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU with the same operands → 0.
- Shifts:
  - SRA `b = 0x80000000`, `sa = 4` → 0xF8000000.
  - SRL with the same operands → 0x08000000.
  - SLLV `a = 0x00000021`, `b = 1` → 2 (only `a[4:0]` used).
  - LUI `b = 0x0000ABCD` → 0xABCD0000.
- Default: `control = 1111` with any operands → `r = 0`, `zero = 1`.

Source files
------------

// File: rtl/mips_cpu_alu_regfile.sv
// mips_cpu_alu_regfile
// Execution core of the multicycle MIPS CPU: a 32 x 32-bit register file
// and a combinational 32-bit ALU.
//
// Ports
//   clk, reset           system clock, synchronous active-low reset
//   writeEnable          register write strobe
//   writeAddress/dataIn  write port (index 0 is discarded)
//   readAddressA/B       combinational read port indices
//   readDataA/B          read port data
//   register_v0          contents of $2, always visible
//   control, a, b, sa    ALU operation code, operands, constant shift amount
//   r, zero              ALU result and (r == 0) flag
module mips_cpu_alu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        writeEnable,
    input  logic [4:0]  writeAddress,
    input  logic [31:0] dataIn,
    input  logic [4:0]  readAddressA,
    output logic [31:0] readDataA,
    input  logic [4:0]  readAddressB,
    output logic [31:0] readDataB,
    output logic [31:0] register_v0,
    input  logic [3:0]  control,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  sa,
    output logic [31:0] r,
    output logic        zero
);

    logic [31:0] regs_q [32];
    logic [31:0] r_d;
    logic [4:0]  shamt_var;

    // Reset takes priority over any write on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeEnable && (writeAddress != 5'd0)) begin
            regs_q[writeAddress] <= dataIn;
        end
    end

    // $zero is forced on the read side so it never depends on storage.
    assign readDataA   = (readAddressA == 5'd0) ? 32'h0 : regs_q[readAddressA];
    assign readDataB   = (readAddressB == 5'd0) ? 32'h0 : regs_q[readAddressB];
    assign register_v0 = regs_q[2];

    assign shamt_var = a[4:0];

    always_comb begin
        r_d = 32'h0;
        case (control)
            4'b0000: r_d = a & b;
            4'b0001: r_d = a | b;
            4'b0010: r_d = a ^ b;
            4'b0011: r_d = {b[15:0], 16'h0};
            4'b0100: r_d = a + b;
            4'b0101: r_d = a - b;
            4'b0110: r_d = {31'h0, ($signed(a) < $signed(b))};
            4'b0111: r_d = {31'h0, (a < b)};
            4'b1000: r_d = b << sa;
            4'b1001: r_d = b >> sa;
            4'b1010: r_d = $signed(b) >>> sa;
            4'b1011: r_d = b << shamt_var;
            4'b1100: r_d = b >> shamt_var;
            4'b1101: r_d = $signed(b) >>> shamt_var;
            4'b1110: r_d = a;
            default: r_d = 32'h0;
        endcase
    end

    assign r    = r_d;
    assign zero = (r_d == 32'h0);

endmodule

// File: tb/tb_mips_cpu_alu_regfile.sv
module tb_mips_cpu_alu_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        writeEnable;
    logic [4:0]  writeAddress;
    logic [31:0] dataIn;
    logic [4:0]  readAddressA;
    logic [31:0] readDataA;
    logic [4:0]  readAddressB;
    logic [31:0] readDataB;
    logic [31:0] register_v0;
    logic [3:0]  control;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] r;
    logic        zero;

    mips_cpu_alu_regfile dut (
        .clk(clk), .reset(reset),
        .writeEnable(writeEnable), .writeAddress(writeAddress), .dataIn(dataIn),
        .readAddressA(readAddressA), .readDataA(readDataA),
        .readAddressB(readAddressB), .readDataB(readDataB),
        .register_v0(register_v0),
        .control(control), .a(a), .b(b), .sa(sa),
        .r(r), .zero(zero)
    );

    always #5 clk = ~clk;

    // kind: 0 readDataA, 1 readDataB, 2 register_v0, 3 r, 4 zero
    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int checks = 0;
    int passed = 0;

    longint unsigned model [32];

    localparam longint M32 = 64'sd4294967296;

    // Reference ALU in plain integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] av,
                                            input logic [31:0] bv, input logic [4:0] sav);
        longint ua, ub, sa_s, sb_s, p, res;
        int sh;
        ua   = longint'({32'h0, av});
        ub   = longint'({32'h0, bv});
        sa_s = (ua >= 64'sd2147483648) ? ua - M32 : ua;
        sb_s = (ub >= 64'sd2147483648) ? ub - M32 : ub;
        sh   = (ctl >= 4'd11) ? int'(ua % 32) : int'(sav);
        p    = 64'sd1 << sh;
        res  = 0;
        case (ctl)
            4'd0:  return av & bv;
            4'd1:  return av | bv;
            4'd2:  return av ^ bv;
            4'd3:  res = (ub % 65536) * 65536;
            4'd4:  res = (ua + ub) % M32;
            4'd5:  res = (ua - ub + M32) % M32;
            4'd6:  res = (sa_s < sb_s) ? 1 : 0;
            4'd7:  res = (ua < ub) ? 1 : 0;
            4'd8, 4'd11:  res = (ub * p) % M32;
            4'd9, 4'd12:  res = ub / p;
            4'd10, 4'd13: begin
                if (sb_s >= 0) res = sb_s / p;
                else           res = -((-sb_s + p - 1) / p);
                if (res < 0) res = res + M32;
            end
            4'd14: res = ua;
            default: res = 0;
        endcase
        return res[31:0];
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : model[idx][31:0];
    endfunction

    // One cycle of stimulus: drive after the edge, queue expectations, then
    // advance the model to what the next edge will commit.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] din, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [3:0] ctl, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sav, input string tag);
        logic [31:0] ar;
        @(posedge clk);
        #1;
        reset = rst; writeEnable = we; writeAddress = wa; dataIn = din;
        readAddressA = ra; readAddressB = rb;
        control = ctl; a = av; b = bv; sa = sav;
        ar = ref_alu(ctl, av, bv, sav);
        q.push_back('{0, model_rd(ra), {tag, ".rdA"}});
        q.push_back('{1, model_rd(rb), {tag, ".rdB"}});
        q.push_back('{2, model_rd(5'd2), {tag, ".v0"}});
        q.push_back('{3, ar, {tag, ".r"}});
        q.push_back('{4, {31'h0, (ar == 32'h0)}, {tag, ".zero"}});
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 0;
        end else if (we && wa != 5'd0) begin
            model[wa] = longint'({32'h0, din});
        end
    endtask

    task automatic alu_case(input logic [3:0] ctl, input logic [31:0] av, input logic [31:0] bv,
                            input logic [4:0] sav, input logic [31:0] exp_r, input logic exp_z,
                            input string tag);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, ctl, av, bv, sav, tag);
        q.push_back('{3, exp_r, {tag, ".r_const"}});
        q.push_back('{4, {31'h0, exp_z}, {tag, ".zero_const"}});
    endtask

    // Monitor: consumes everything queued for this cycle, away from the edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            item_t it;
            logic [31:0] act;
            it = q.pop_front();
            case (it.kind)
                0: act = readDataA;
                1: act = readDataB;
                2: act = register_v0;
                3: act = r;
                default: act = {31'h0, zero};
            endcase
            checks++;
            if (act === it.exp) passed++;
            else $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rv;
        reset = 1'b0; writeEnable = 1'b0; writeAddress = '0; dataIn = '0;
        readAddressA = '0; readAddressB = '0; control = 4'hF; a = '0; b = '0; sa = '0;
        for (int i = 0; i < 32; i++) model[i] = 0;
        @(posedge clk);
        #1;

        // Reset, then read every index on both ports.
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 4'hF, 32'h0, 32'h0, 5'd0, "reset");
        for (int i = 0; i < 32; i++)
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 4'hF, 32'h0, 32'h0, 5'd0, "rst_read");

        // Write/read and $zero.
        drive(1'b1, 1'b1, 5'd2, 32'hDEADBEEF, 5'd2, 5'd2, 4'hE, 32'h1, 32'h0, 5'd0, "wr_v0");
        drive(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd2, 5'd2, 4'hE, 32'h1, 32'h0, 5'd0, "rd_v0");
        q.push_back('{2, 32'hDEADBEEF, "v0_const"});
        q.push_back('{0, 32'hDEADBEEF, "v0_portA_const"});
        drive(1'b1, 1'b1, 5'd5, 32'h0000A5A5, 5'd0, 5'd0, 4'hE, 32'h0, 32'h0, 5'd0, "rd_r0");
        q.push_back('{0, 32'h0, "r0_const"});
        drive(1'b1, 1'b0, 5'd5, 32'h00001111, 5'd5, 5'd0, 4'hE, 32'h0, 32'h0, 5'd0, "we0");
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 4'hE, 32'h0, 32'h0, 5'd0, "we0_chk");
        q.push_back('{0, 32'h0000A5A5, "we0_const"});

        // Reset priority over a write on the same edge.
        drive(1'b1, 1'b1, 5'd7, 32'h00000099, 5'd7, 5'd0, 4'hE, 32'h0, 32'h0, 5'd0, "pre_rst7");
        drive(1'b0, 1'b1, 5'd7, 32'h00000055, 5'd7, 5'd2, 4'hE, 32'h0, 32'h0, 5'd0, "rst_wr7");
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd2, 4'hE, 32'h0, 32'h0, 5'd0, "rst_prio");
        q.push_back('{0, 32'h0, "rst_prio_r7_const"});
        q.push_back('{2, 32'h0, "rst_prio_v0_const"});

        // Directed ALU cases.
        alu_case(4'h4, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1, "add_wrap");
        alu_case(4'h4, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, "add_ovf");
        alu_case(4'h5, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0, "sub");
        alu_case(4'h6, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, "slt");
        alu_case(4'h7, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1, "sltu");
        alu_case(4'hA, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, "sra");
        alu_case(4'h9, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 1'b0, "srl");
        alu_case(4'hB, 32'h00000021, 32'h1, 5'd0, 32'h2, 1'b0, "sllv");
        alu_case(4'h3, 32'h0, 32'h0000ABCD, 5'd0, 32'hABCD0000, 1'b0, "lui");
        alu_case(4'hF, 32'h12345678, 32'h9ABCDEF0, 5'd7, 32'h0, 1'b1, "default");
        alu_case(4'hD, 32'hFFFFFFE4, 32'h80000010, 5'd0, 32'hF8000001, 1'b0, "srav");
        alu_case(4'hC, 32'hFFFFFFE4, 32'h80000010, 5'd0, 32'h08000001, 1'b0, "srlv");
        alu_case(4'h8, 32'h0, 32'h00000003, 5'd31, 32'h80000000, 1'b0, "sll");
        alu_case(4'h0, 32'hF0F0FFFF, 32'h0FF0F00F, 5'd0, 32'h00F0F00F, 1'b0, "and");
        alu_case(4'h1, 32'hF0000000, 32'h0000000F, 5'd0, 32'hF000000F, 1'b0, "or");
        alu_case(4'h2, 32'hFFFF0000, 32'hFF00FF00, 5'd0, 32'h00FFFF00, 1'b0, "xor");
        alu_case(4'hE, 32'hCAFEF00D, 32'h0, 5'd0, 32'hCAFEF00D, 1'b0, "pass");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] av, bv;
            av = $urandom();
            bv = $urandom();
            if ($urandom_range(0, 3) == 0) bv = $urandom_range(0, 3) == 0 ? 32'h0 : av;
            drive(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  4'($urandom_range(0, 15)), av, bv, 5'($urandom_range(0, 31)), "rand");
        end

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d items left, expected 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
